// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous single-port memory between the
// instruction-fetch requester (read-only) and the load/store requester.
// One transaction is outstanding at a time. Data wins when both request,
// unless fetch has already waited through STARVE_LIMIT data grants.
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   i_req/i_addr -> i_gnt               fetch request handshake
//   i_rvalid/i_rdata                    fetch response (one-cycle pulse)
//   d_req/d_we/d_addr/d_wdata -> d_gnt  load/store request handshake
//   d_done/d_rdata                      load/store response (one-cycle pulse)
//   mem_addr/mem_data_in/mem_write      registered memory command
//   mem_data_out                        memory read data
//   busy                                FSM is outside IDLE
module mem_port_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [DATA_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_done,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [3:0] LAT_LAST   = 4'(MEM_LATENCY - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_e                state_q, state_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic [3:0]            starve_q, starve_d;
    logic                  mem_write_q, mem_write_d;
    logic                  owner_q;     // 1 = data port owns the transaction
    logic                  we_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  i_rvalid_q, d_done_q;
    logic [DATA_WIDTH-1:0] i_rdata_q, d_rdata_q;

    logic                  pick_d_s;
    logic                  i_gnt_s, d_gnt_s;

    // Arbitration: data wins unless fetch has been passed over STARVE_LIMIT times.
    // The grant is combinational so it lands in the same cycle as the request;
    // it is masked by rst_n so every output reads 0 while reset is held.
    always_comb begin
        pick_d_s = d_req & (~i_req | (starve_q < STARVE_MAX));
        if ((state_q == ST_IDLE) && rst_n) begin
            d_gnt_s = pick_d_s;
            i_gnt_s = i_req & ~pick_d_s;
        end else begin
            d_gnt_s = 1'b0;
            i_gnt_s = 1'b0;
        end
    end

    // Next-state logic for the FSM, wait counter, starvation counter and write strobe.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        starve_d    = starve_q;
        mem_write_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_gnt_s || d_gnt_s) begin
                    state_d     = ST_WAIT;
                    wait_cnt_d  = 4'd0;
                    // Write strobe is registered so it covers only the first WAIT cycle.
                    mem_write_d = d_gnt_s & d_we;
                    if (i_gnt_s) begin
                        starve_d = 4'd0;
                    end else if (i_req && (starve_q != 4'hF)) begin
                        starve_d = starve_q + 4'd1;
                    end else begin
                        starve_d = starve_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q + 4'd1;
                if (wait_cnt_q == LAT_LAST) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, counters and write strobe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= 4'd0;
            starve_q    <= 4'd0;
            mem_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            starve_q    <= starve_d;
            mem_write_q <= mem_write_d;
        end
    end

    // Transaction latch: captured on the grant edge, held through WAIT and RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (d_gnt_s) begin
            owner_q <= 1'b1;
            we_q    <= d_we;
            addr_q  <= d_addr;
            wdata_q <= d_wdata;
        end else if (i_gnt_s) begin
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= i_addr;
            wdata_q <= '0;
        end else begin
            owner_q <= owner_q;
            we_q    <= we_q;
            addr_q  <= addr_q;
            wdata_q <= wdata_q;
        end
    end

    // Response capture on the edge leaving RESP; rdata holds until that port's next response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_rvalid_q <= 1'b0;
            d_done_q   <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            i_rvalid_q <= (state_q == ST_RESP) & ~owner_q;
            d_done_q   <= (state_q == ST_RESP) & owner_q;
            if ((state_q == ST_RESP) && !owner_q) begin
                i_rdata_q <= mem_data_out;
            end else begin
                i_rdata_q <= i_rdata_q;
            end
            if ((state_q == ST_RESP) && owner_q) begin
                d_rdata_q <= we_q ? '0 : mem_data_out;
            end else begin
                d_rdata_q <= d_rdata_q;
            end
        end
    end

    assign i_gnt       = i_gnt_s;
    assign d_gnt       = d_gnt_s;
    assign i_rvalid    = i_rvalid_q;
    assign i_rdata     = i_rdata_q;
    assign d_done      = d_done_q;
    assign d_rdata     = d_rdata_q;
    assign mem_addr    = addr_q;
    assign mem_data_in = wdata_q;
    assign mem_write   = mem_write_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int DW  = 32;
    localparam int LAT = 3;
    localparam int SL  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req, d_req, d_we;
    logic [DW-1:0] i_addr, d_addr, d_wdata;
    logic          i_gnt, i_rvalid, d_gnt, d_done, mem_write, busy;
    logic [DW-1:0] i_rdata, d_rdata, mem_addr, mem_data_in, mem_data_out;

    mem_port_arbiter #(.DATA_WIDTH(DW), .MEM_LATENCY(LAT), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_write(mem_write),
        .mem_data_out(mem_data_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory instance driven by the DUT: LAT-stage read pipeline, write on the edge.
    logic [DW-1:0] ram [512];
    logic [DW-1:0] rd_pipe [LAT];
    always @(posedge clk) begin
        if (mem_write) ram[mem_addr[8:0]] <= mem_data_in;
        rd_pipe[0] <= ram[mem_addr[8:0]];
        for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_data_out = rd_pipe[LAT-1];

    // Scoreboard records.
    typedef struct {
        logic ig, dg, bsy, mw, chk_addr, chk_wd;
        logic [DW-1:0] addr, wdata;
    } cyc_t;
    typedef struct {
        logic          is_d;
        logic [DW-1:0] data;
        int            due;
    } resp_t;

    cyc_t  cyc_q[$];
    resp_t resp_q[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Reference model: transaction-level view of the arbiter.
    logic [DW-1:0] ref_mem [512];
    int            m_busy = 0;
    int            m_starve = 0;
    logic          p_mw = 1'b0, p_chk = 1'b0, m_win_d;
    logic [DW-1:0] p_addr, p_wd, m_a;
    cyc_t          m_e;
    resp_t         m_r;

    always @(negedge clk) begin
        if (!rst_n) begin
            cyc_q.delete();
            resp_q.delete();
            m_busy = 0;
            m_starve = 0;
            p_mw = 1'b0;
            p_chk = 1'b0;
        end else begin
            cyc++;
            m_e.ig = 1'b0; m_e.dg = 1'b0;
            m_e.bsy = (m_busy > 0);
            m_e.mw = p_mw; m_e.chk_addr = p_chk; m_e.chk_wd = p_mw;
            m_e.addr = p_addr; m_e.wdata = p_wd;
            // A store reaches memory only if no reset hit its first WAIT cycle.
            if (p_mw) ref_mem[p_addr[8:0]] = p_wd;
            p_mw = 1'b0;
            p_chk = 1'b0;
            if (m_busy > 0) begin
                m_busy--;
            end else if (i_req || d_req) begin
                m_win_d = d_req && (!i_req || m_starve < SL);
                if (!m_win_d) m_starve = 0;
                else if (i_req && m_starve < 15) m_starve++;
                m_e.dg = m_win_d;
                m_e.ig = !m_win_d;
                m_a = m_win_d ? d_addr : i_addr;
                m_r.is_d = m_win_d;
                m_r.due = cyc + LAT + 2;
                m_r.data = (m_win_d && d_we) ? 32'h0 : ref_mem[m_a[8:0]];
                resp_q.push_back(m_r);
                p_mw = m_win_d && d_we;
                p_chk = 1'b1;
                p_addr = m_a;
                p_wd = d_wdata;
                m_busy = LAT + 1;
            end
            cyc_q.push_back(m_e);
        end
    end

    // Monitor: compares DUT outputs with the scoreboard each cycle.
    cyc_t  e;
    resp_t r;
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            chk("reset_outputs", {31'h0, i_gnt | d_gnt | i_rvalid | d_done | mem_write | busy |
                (|i_rdata) | (|d_rdata) | (|mem_addr) | (|mem_data_in)}, 32'h0);
        end else begin
            if (cyc_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL cyc_record cyc=%0d actual=empty required=record", cyc);
            end else begin
                e = cyc_q.pop_front();
                chk("i_gnt", {31'h0, i_gnt}, {31'h0, e.ig});
                chk("d_gnt", {31'h0, d_gnt}, {31'h0, e.dg});
                chk("busy", {31'h0, busy}, {31'h0, e.bsy});
                chk("mem_write", {31'h0, mem_write}, {31'h0, e.mw});
                if (e.chk_addr) chk("mem_addr", mem_addr, e.addr);
                if (e.chk_wd) chk("mem_data_in", mem_data_in, e.wdata);
            end
            if (i_rvalid || d_done) begin
                if (resp_q.size() == 0 || resp_q[0].due != cyc) begin
                    checks++; failures++;
                    $display("FAIL unexpected_resp cyc=%0d actual=rv%0b/dd%0b required=none", cyc, i_rvalid, d_done);
                end else begin
                    r = resp_q.pop_front();
                    chk("resp_d_done", {31'h0, d_done}, {31'h0, r.is_d});
                    chk("resp_i_rvalid", {31'h0, i_rvalid}, {31'h0, !r.is_d});
                    chk("resp_rdata", r.is_d ? d_rdata : i_rdata, r.data);
                end
            end else if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
                checks++; failures++;
                $display("FAIL missing_resp cyc=%0d actual=none required=due%0d", cyc, resp_q[0].due);
                void'(resp_q.pop_front());
            end
        end
    end

    // Stimulus helpers.
    logic ig_s, dg_s;
    bit   rec = 1'b0;
    byte  gseq[$];

    task automatic step();
        @(negedge clk);
        #1;
        ig_s = i_gnt;
        dg_s = d_gnt;
        if (rec && dg_s) gseq.push_back(8'h44);
        if (rec && ig_s) gseq.push_back(8'h49);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input bit is_d);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(is_d ? dg_s : ig_s) && n < 200);
        checks++;
        if (n >= 200) begin
            failures++;
            $display("FAIL gnt_timeout actual=none required=gnt");
        end
    endtask

    task automatic drain();
        repeat (LAT + 4) step();
    endtask

    string exp_order = "DDDDIDDDDI";

    initial begin
        for (int i = 0; i < 512; i++) begin
            ram[i] = (i * 32'h01010101) ^ 32'hA5A50000;
            ref_mem[i] = ram[i];
        end
        ram[9'h010] = 32'h00500093; ref_mem[9'h010] = 32'h00500093;
        ram[9'h008] = 32'h12345678; ref_mem[9'h008] = 32'h12345678;
        for (int k = 0; k < LAT; k++) rd_pipe[k] = 32'h0;
        rst_n = 1'b0;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // Single fetch.
        i_req = 1'b1; i_addr = 32'h10;
        wait_gnt(1'b0);
        i_req = 1'b0;
        drain();

        // Store then load at 0x40, then load at 0x8.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
        wait_gnt(1'b1);
        d_req = 1'b0;
        drain();
        d_req = 1'b1; d_we = 1'b0;
        wait_gnt(1'b1);
        d_addr = 32'h8;
        wait_gnt(1'b1);
        d_req = 1'b0;
        drain();

        // Randomised traffic; requests held until granted, back-to-back allowed.
        for (int n = 0; n < 600; n++) begin
            step();
            if (!i_req || ig_s) begin
                i_req = 1'($urandom_range(0, 1));
                i_addr = 32'($urandom_range(0, 255));
            end
            if (!d_req || dg_s) begin
                d_req = 1'($urandom_range(0, 1));
                d_we = 1'($urandom_range(0, 1));
                d_addr = 32'($urandom_range(0, 255));
                d_wdata = $urandom;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        drain();

        // Reset in the first WAIT cycle of a store: the store and its response are dropped.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hCAFEF00D;
        wait_gnt(1'b1);
        d_req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("reset_immediate", {31'h0, busy | mem_write | d_gnt | d_done | (|mem_addr) | (|mem_data_in)}, 32'h0);
        step(); step();
        rst_n = 1'b1;
        step();
        d_we = 1'b0; d_req = 1'b1;
        wait_gnt(1'b1);
        d_req = 1'b0;
        drain();

        // Starvation guard with both requests held (starve count is 0 after reset).
        gseq.delete();
        rec = 1'b1;
        i_req = 1'b1; i_addr = 32'h20; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
        for (int n = 0; n < 300 && gseq.size() < 10; n++) step();
        rec = 1'b0;
        i_req = 1'b0; d_req = 1'b0;
        drain();
        chk("starve_count", gseq.size(), 10);
        for (int k = 0; k < 10 && k < gseq.size(); k++)
            chk("starve_order", {24'h0, gseq[k]}, {24'h0, exp_order[k]});

        chk("resp_drained", resp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
